// File: rtl/jtopl_timers_if.sv
// Register-side bus for the OPL timer block: reload values, run bits,
// masks and flag clear in; sticky flags, irq and timer A overflow out.
interface jtopl_timers_if;
  logic [7:0] value_a;
  logic [7:0] value_b;
  logic       load_a;
  logic       load_b;
  logic       mask_a;
  logic       mask_b;
  logic       flag_clr;
  logic       flag_a;
  logic       flag_b;
  logic       irq_n;
  logic       ovf_a;

  modport master (
    output value_a, value_b, load_a, load_b, mask_a, mask_b, flag_clr,
    input  flag_a, flag_b, irq_n, ovf_a
  );

  modport slave (
    input  value_a, value_b, load_a, load_b, mask_a, mask_b, flag_clr,
    output flag_a, flag_b, irq_n, ovf_a
  );
endinterface

// File: rtl/jtopl_timers.sv
// OPL timers A and B: free-running prescaler (PRESC cenop per timer A tick),
// /T2DIV divider for timer B ticks, two 8-bit reloading up-counters,
// sticky flags with masks, registered irq_n and a timer A overflow pulse.
// Define JTOPL_TIMERS_FAST_EN to bypass the prescaler (tick_a = cenop) for
// fast simulation; the default build keeps the full prescaler.

// One 8-bit timer: STOP/RUN, loads on a run-bit rising edge, reloads on overflow
module jtopl_timer_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] value,
  output logic       ovf
);
  typedef enum logic {STOP = 1'b0, RUN = 1'b1} st_t;

  st_t        st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ld_q;

  // State, counter and previous run bit registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= STOP;
      cnt_q <= 8'd0;
      ld_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ld_q  <= load;
    end
  end

  // Next state: a run-bit rise loads value and wins over any tick that clk;
  // a low run bit stops and freezes the count; 0xFF reloads instead of wrapping
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (load && !ld_q) begin
      st_d  = RUN;
      cnt_d = value;
    end else if (!load) begin
      st_d  = STOP;
    end else if (st_q == RUN && tick) begin
      if (cnt_q == 8'hFF) begin
        cnt_d = value;
        ovf   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end
endmodule

module jtopl_timers #(
  parameter int PRESC = 72,
  parameter int T2DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cenop,
  jtopl_timers_if.slave  bus
);
  localparam int BW = (T2DIV > 1) ? $clog2(T2DIV) : 1;

  logic          tick_a, tick_b;
  logic [BW-1:0] cnt_b;
  logic [1:0]        tick, load, ovf;
  logic [1:0][7:0]   value;
  logic          flag_a_q, flag_b_q, irq_n_q, ovf_a_q;

`ifdef JTOPL_TIMERS_FAST_EN
  assign tick_a = cenop;
`else
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  logic [PW-1:0] cnt_p;

  // Prescaler: counts cenop pulses 0..PRESC-1, tick_a on the wrapping pulse
  always_ff @(posedge clk) begin
    if (!rst)
      cnt_p <= '0;
    else if (cenop)
      cnt_p <= (cnt_p == PW'(PRESC - 1)) ? '0 : cnt_p + PW'(1);
  end

  assign tick_a = cenop && (cnt_p == PW'(PRESC - 1));
`endif

  // Timer B divider: counts tick_a 0..T2DIV-1, tick_b on the wrapping tick
  always_ff @(posedge clk) begin
    if (!rst)
      cnt_b <= '0;
    else if (tick_a)
      cnt_b <= (cnt_b == BW'(T2DIV - 1)) ? '0 : cnt_b + BW'(1);
  end

  assign tick_b = tick_a && (cnt_b == BW'(T2DIV - 1));

  assign tick  = {tick_b, tick_a};
  assign load  = {bus.load_b, bus.load_a};
  assign value = {bus.value_b, bus.value_a};

  for (genvar i = 0; i < 2; i++) begin : g_tmr
    jtopl_timer_cnt u_tmr (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick[i]),
      .load  (load[i]),
      .value (value[i]),
      .ovf   (ovf[i])
    );
  end

  // Flags set one clk after overflow (set beats clear, mask drops the event);
  // irq_n follows the flags one clk later
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      ovf_a_q  <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      flag_a_q <= (ovf[0] & ~bus.mask_a) | (flag_a_q & ~bus.flag_clr);
      flag_b_q <= (ovf[1] & ~bus.mask_b) | (flag_b_q & ~bus.flag_clr);
      ovf_a_q  <= ovf[0];
      irq_n_q  <= ~(flag_a_q | flag_b_q);
    end
  end

  assign bus.flag_a = flag_a_q;
  assign bus.flag_b = flag_b_q;
  assign bus.ovf_a  = ovf_a_q;
  assign bus.irq_n  = irq_n_q;
endmodule

// File: tb/tb_jtopl_timers.sv
// Bench for jtopl_timers: directed table, hand sequences for the
// multi-cycle corners, and a randomized run against a lockstep model.
module tb_jtopl_timers;
  localparam int PRESC = 72;
  localparam int T2DIV = 4;
`ifdef JTOPL_TIMERS_FAST_EN
  localparam int PA = 1;
`else
  localparam int PA = PRESC;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cenop = 1'b0;

  jtopl_timers_if bus ();

  jtopl_timers #(.PRESC(PRESC), .T2DIV(T2DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .cenop (cenop),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ticks derived from total cenop / tick counts since reset; timers follow
  // the load / reload / overflow rules directly.
  int         m_ncen = 0;
  int         m_nta  = 0;
  bit  [1:0]  m_run  = '0;
  int         m_cnt [2];
  bit  [1:0]  m_pl   = '0;
  bit         m_fa = 1'b0, m_fb = 1'b0, m_ovfa = 1'b0, m_irqn = 1'b1;
  logic [1:0]      m_ld, m_tk, m_ov;
  logic [1:0][7:0] m_vl;
  logic            m_ta, m_tb;

  assign m_ta  = cenop && ((m_ncen % PA) == PA - 1);
  assign m_tb  = m_ta && ((m_nta % T2DIV) == T2DIV - 1);
  assign m_tk  = {m_tb, m_ta};
  assign m_ld  = {bus.load_b, bus.load_a};
  assign m_vl  = {bus.value_b, bus.value_a};
  assign m_ov[0] = m_ld[0] && m_pl[0] && m_run[0] && m_tk[0] && (m_cnt[0] == 255);
  assign m_ov[1] = m_ld[1] && m_pl[1] && m_run[1] && m_tk[1] && (m_cnt[1] == 255);

  always @(posedge clk) begin
    if (!rst) begin
      m_ncen <= 0;
      m_nta  <= 0;
      m_run  <= '0;
      m_pl   <= '0;
      m_cnt[0] <= 0;
      m_cnt[1] <= 0;
      m_fa   <= 1'b0;
      m_fb   <= 1'b0;
      m_ovfa <= 1'b0;
      m_irqn <= 1'b1;
    end else begin
      m_ncen <= m_ncen + int'(cenop);
      m_nta  <= m_nta + int'(m_ta);
      for (int x = 0; x < 2; x++) begin
        if (m_ld[x] && !m_pl[x]) begin
          m_run[x] <= 1'b1;
          m_cnt[x] <= int'(m_vl[x]);
        end else if (!m_ld[x]) begin
          m_run[x] <= 1'b0;
        end else if (m_run[x] && m_tk[x]) begin
          m_cnt[x] <= m_ov[x] ? int'(m_vl[x]) : m_cnt[x] + 1;
        end
      end
      m_pl   <= m_ld;
      m_fa   <= (m_ov[0] && !bus.mask_a) || (m_fa && !bus.flag_clr);
      m_fb   <= (m_ov[1] && !bus.mask_b) || (m_fb && !bus.flag_clr);
      m_ovfa <= m_ov[0];
      m_irqn <= !(m_fa || m_fb);
    end
  end

  // Lockstep comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ls_ovf_a",  bus.ovf_a,  m_ovfa);
      check("ls_flag_a", bus.flag_a, m_fa);
      check("ls_flag_b", bus.flag_b, m_fb);
      check("ls_irq_n",  bus.irq_n,  m_irqn);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit       rst;
    bit [7:0] va, vb;
    bit       la, lb, ma, mb, clr;
    int       n;
    bit       efa, efb, eirq;
    int       eovf;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt, to, seen, first;

    //         rst  va     vb     la lb ma mb clr  n    fa fb irq ovf
    tbl[0] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0,   4,  0, 0, 1, 0};
    tbl[1] = '{1'b1, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 100,  1, 0, 0, 1};
    tbl[2] = '{1'b1, 8'hFF, 8'h00, 1, 0, 0, 0, 1,   1,  0, 0, 0, 0};
    tbl[3] = '{1'b1, 8'hFF, 8'h00, 1, 0, 0, 0, 0,   1,  0, 0, 1, 0};
    tbl[4] = '{1'b1, 8'hFF, 8'h00, 1, 0, 1, 0, 0,  60,  0, 0, 1, 1};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 1, 0, 0, 0, 0,  10,  0, 0, 1, 0};
    tbl[6] = '{1'b1, 8'hFF, 8'h00, 0, 0, 0, 0, 0,  80,  0, 0, 1, 0};
    tbl[7] = '{1'b1, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 300,  0, 1, 0, 0};
    tbl[8] = '{1'b1, 8'hFF, 8'hFF, 0, 1, 0, 0, 1,   1,  0, 0, 0, 0};

    bus.value_a = 8'h00; bus.value_b = 8'h00;
    bus.load_a = 1'b0;   bus.load_b = 1'b0;
    bus.mask_a = 1'b0;   bus.mask_b = 1'b0;
    bus.flag_clr = 1'b0;
    rst = 1'b0;
    cenop = 1'b1;
    step();
    chk_en = 1'b1;

`ifndef JTOPL_TIMERS_FAST_EN
    // Rows assume cenop every clk and the full prescaler: ticks at 72, 144, ...
    for (int r = 0; r < 9; r++) begin
      rst = tbl[r].rst;
      bus.value_a = tbl[r].va; bus.value_b = tbl[r].vb;
      bus.load_a = tbl[r].la;  bus.load_b = tbl[r].lb;
      bus.mask_a = tbl[r].ma;  bus.mask_b = tbl[r].mb;
      bus.flag_clr = tbl[r].clr;
      cnt = 0;
      for (int i = 0; i < tbl[r].n; i++) begin
        step();
        cnt += int'(bus.ovf_a);
      end
      check($sformatf("row%0d_flag_a", r), bus.flag_a, tbl[r].efa);
      check($sformatf("row%0d_flag_b", r), bus.flag_b, tbl[r].efb);
      check($sformatf("row%0d_irq_n", r),  bus.irq_n,  tbl[r].eirq);
      check($sformatf("row%0d_ovf_cnt", r), cnt, tbl[r].eovf);
    end
`endif
    rst = 1'b1;
    bus.flag_clr = 1'b0;
    bus.value_b = 8'hFF;
    bus.load_b = 1'b1;

    // Stop at 0x80: counter frozen, no overflow; restart reloads value_a
    bus.value_a = 8'h80;
    bus.load_a = 1'b1;
    repeat (5) step();
    bus.load_a = 1'b0;
    bus.value_a = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      cnt += int'(bus.ovf_a);
    end
    check("s5_stopped_ovf", cnt, 0);
    bus.load_a = 1'b1;
    cnt = 0;
    for (int i = 0; i < 73; i++) begin
      step();
      cnt += int'(bus.ovf_a);
    end
    check("s5_restart_ovf", cnt, (PA == 1) ? 72 : 1);
    check("s5_flag_a", bus.flag_a, 1);

    // One-clk reset mid-count: flags drop, timer restarts from value_a
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("s6_flag_a", bus.flag_a, 0);
    check("s6_flag_b", bus.flag_b, 0);
    check("s6_irq_n",  bus.irq_n,  1);
    check("s6_ovf_a",  bus.ovf_a,  0);
    first = (PA == 1) ? 2 : PA;
    seen = 0;
    for (int i = 1; i <= first + 5; i++) begin
      step();
      if (bus.ovf_a && seen == 0) seen = i;
    end
    check("s6_first_ovf", seen, first);

    // flag_clr coincident with a timer A overflow, flag_b previously set
    to = 0;
    while (!m_fb && to < 4 * PA * T2DIV + 20) begin
      step();
      to++;
    end
    check("s4_wait_flag_b", bus.flag_b, 1);
    to = 0;
    while (((m_ncen % PA) != PA - 1) && to < PA + 5) begin
      step();
      to++;
    end
    check("s4_wait_tick", ((m_ncen % PA) == PA - 1), 1);
    bus.flag_clr = 1'b1;
    step();
    bus.flag_clr = 1'b0;
    check("s4_flag_a", bus.flag_a, 1);
    check("s4_flag_b", bus.flag_b, 0);
    check("s4_ovf_a",  bus.ovf_a,  1);
    step();
    check("s4_irq_n",  bus.irq_n,  0);

    // Randomized run, checked by the lockstep model
    for (int c = 0; c < 20000; c++) begin
      cenop = ($urandom_range(3) != 0);
      bus.flag_clr = ($urandom_range(199) == 0);
      if ($urandom_range(2999) == 0) bus.load_a = ~bus.load_a;
      if ($urandom_range(2999) == 0) bus.load_b = ~bus.load_b;
      if ($urandom_range(1999) == 0) bus.mask_a = ~bus.mask_a;
      if ($urandom_range(1999) == 0) bus.mask_b = ~bus.mask_b;
      if ($urandom_range(499) == 0) bus.value_a = 8'hF0 | 8'($urandom_range(15));
      if ($urandom_range(499) == 0) bus.value_b = 8'hF0 | 8'($urandom_range(15));
      rst = ($urandom_range(4999) != 0);
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
